ads131_init_sequencer: RTL and testbench
========================================

Name: ads131_init_sequencer

Overview:
- Controller that brings the ADS131A0x ADC from power-up to continuous conversion, then schedules data-frame reads on each DRDY.
- Issues 16-bit command words to the existing SPI transaction engine through a req/done handshake and checks every device response.
- Owns the ADC hardware reset pin.
- Sits between top-level control (start/status) and the SPI master.

Parameters:
- RESET_LOW_CYCLES, 50, system_clock cycles the ADC reset pin is held low (1 us at 50 MHz).
- RESET_WAIT_CYCLES, 2500, cycles to wait after reset release before the first poll.
- READY_POLLS, 64, maximum NULL polls for the READY word before flagging an error.
- READY_WORD, 16'hFF04, expected READY response (A04 variant).
- CFG_COUNT, 5, number of WREG entries in the config table.

Ports:
- system_clock  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the init sequence from IDLE or ERROR
- drdy  in  1  ADC DRDY, active-low; already synchronised by the caller
- adc_reset_n  out  1  drives the ADC RESET pin
- xfer_req  out  1  transaction request to the SPI engine; level, held until xfer_done
- xfer_cmd  out  16  command word; stable while xfer_req is high
- xfer_done  in  1  one-cycle pulse; transaction complete, xfer_resp valid
- xfer_resp  in  16  response word from the previous frame
- frame_req  out  1  one-cycle pulse requesting a full data-frame read (RUN state only)
- busy  out  1  high in every state except IDLE, RUN and ERROR
- ready  out  1  high in RUN
- error  out  1  high in ERROR
- error_code  out  3  1 = READY timeout, 2 = UNLOCK mismatch, 3 = WREG mismatch, 4 = WAKEUP/LOCK mismatch

Behaviour:
- Reset values:
  - adc_reset_n = 1; xfer_req = 0; xfer_cmd = 0; frame_req = 0; busy = 0; ready = 0; error = 0; error_code = 0.
  - State = IDLE; all counters = 0.
- Reset mid-operation: same values on the next edge. An outstanding xfer_req is dropped; a late xfer_done is ignored in IDLE.
- Command encodings:
  - NULL 0000, UNLOCK 0655, WAKEUP 0033, LOCK 0555.
  - WREG = 4000 | addr<<8 | data. Expected WREG echo = 2000 | addr<<8 | data.
- Response rule: the response to command k arrives in frame k+1. Every command is followed by a NULL transaction, and that NULL's xfer_resp is checked.
- Handshake:
  - xfer_req rises with xfer_cmd in the same cycle and is held until the xfer_done cycle.
  - xfer_req deasserts in the cycle after xfer_done.
  - Minimum one idle cycle between requests.
- FSM states:
  - IDLE: on start → RST_LOW.
  - RST_LOW: adc_reset_n = 0 for RESET_LOW_CYCLES, then → RST_WAIT.
  - RST_WAIT: adc_reset_n = 1; count RESET_WAIT_CYCLES, then → POLL.
  - POLL: issue NULL.
    - resp == READY_WORD → UNLOCK.
    - Otherwise increment the poll count; when the count reaches READY_POLLS → ERROR with code 1.
  - UNLOCK: issue UNLOCK, then NULL; resp must be 0655, else code 2. → CFG.
  - CFG: for idx 0..CFG_COUNT-1, issue WREG from the table, then NULL; resp must equal the echo, else code 3. After the last entry → WAKEUP.
  - WAKEUP: issue WAKEUP + NULL; resp must be 0033.
  - LOCK: issue LOCK + NULL; resp must be 0555. Mismatch in WAKEUP or LOCK → code 4. Success → RUN.
  - RUN: frame_req pulses one cycle after each detected drdy falling edge.
    - A drdy fall during a frame read still produces a pulse; the engine owns overrun handling.
    - start in RUN re-runs the sequence from RST_LOW.
  - ERROR: holds error_code; start → RST_LOW and clears error and error_code.
- start is ignored while busy.
- drdy is ignored outside RUN.
- The edge detector register resets to 1.
- All counters saturate and never wrap.

Decomposition:
- Package ads131_pkg:
  - state enum.
  - command constants (NULL, UNLOCK, WAKEUP, LOCK, WREG/RREG bases, echo base).
  - error_code constants.
  - register addresses (A_SYS_CFG 0B, D_SYS_CFG 0C, CLK1 0D, CLK2 0E, ADC_ENA 0F).
- Sub-module ads131_cfg_rom: combinational, idx → {addr, data}. Default data 60, 3C, 08, 86, 0F.

Test Plan:
- Reset, pulse start, responder returns FF04 on the 3rd NULL → adc_reset_n low exactly 50 cycles; exactly 3 POLL transactions; state reaches UNLOCK.
- Full happy path with a correct-echo responder → command sequence is NULL×n, 0655, 0000, 460B? no: 4B60, 0000, 4C3C, 0000, 4D08, 0000, 4E86, 0000, 4F0F, 0000, 0033, 0000, 0555, 0000; ready = 1, busy = 0.
- Responder never sends FF04 → after 64 polls error = 1, error_code = 1, no further xfer_req; then start → sequence restarts and error clears.
- WREG echo for D_SYS_CFG returns 2C3D → error_code = 3, with no WAKEUP issued.
- In RUN, three drdy falling edges → exactly three one-cycle frame_req pulses, each one cycle after the edge; a drdy held low produces no extra pulses.
- Assert reset during CFG with xfer_req high → next cycle all outputs are at reset values; a subsequent xfer_done has no effect.

Source files
------------

// File: rtl/ads131_pkg.sv
// ----------------------------------------------------------------------------
// ads131_pkg
//   Shared definitions for the ADS131A0x init sequencer: FSM state encoding,
//   SPI command words, error codes, configuration register addresses and
//   small helpers for building WREG commands and their expected echoes.
// ----------------------------------------------------------------------------
package ads131_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_POLL,
        S_UNLOCK,
        S_CFG,
        S_WAKEUP,
        S_LOCK,
        S_RUN,
        S_ERROR
    } state_t;

    // Command words understood by the ADC
    localparam logic [15:0] CMD_NULL       = 16'h0000;
    localparam logic [15:0] CMD_UNLOCK     = 16'h0655;
    localparam logic [15:0] CMD_WAKEUP     = 16'h0033;
    localparam logic [15:0] CMD_LOCK       = 16'h0555;
    localparam logic [15:0] CMD_WREG_BASE  = 16'h4000;
    localparam logic [15:0] CMD_RREG_BASE  = 16'h2000;
    localparam logic [15:0] ECHO_WREG_BASE = 16'h2000;

    // error_code values
    localparam logic [2:0] ERR_NONE          = 3'd0;
    localparam logic [2:0] ERR_READY_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_UNLOCK        = 3'd2;
    localparam logic [2:0] ERR_WREG          = 3'd3;
    localparam logic [2:0] ERR_WAKE_LOCK     = 3'd4;

    // Configuration register addresses
    localparam logic [7:0] A_SYS_CFG = 8'h0B;
    localparam logic [7:0] D_SYS_CFG = 8'h0C;
    localparam logic [7:0] CLK1      = 8'h0D;
    localparam logic [7:0] CLK2      = 8'h0E;
    localparam logic [7:0] ADC_ENA   = 8'h0F;

    // Width shared by the reset-timing and poll counters
    localparam int CNT_W = 16;

    function automatic logic [15:0] wreg_cmd(input logic [7:0] addr, input logic [7:0] data);
        return CMD_WREG_BASE | {addr, data};
    endfunction

    function automatic logic [15:0] wreg_echo(input logic [7:0] addr, input logic [7:0] data);
        return ECHO_WREG_BASE | {addr, data};
    endfunction

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/ads131_cfg_rom.sv
// ----------------------------------------------------------------------------
// ads131_cfg_rom
//   Combinational table of register writes issued during configuration.
//   Ports:
//     idx  in  3  table index (0..4 valid)
//     addr out 8  register address for this entry
//     data out 8  value written to that register
// ----------------------------------------------------------------------------
module ads131_cfg_rom
    import ads131_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] addr,
    output logic [7:0] data
);

    // Indices past the end of the table return zeros; the sequencer never
    // reaches them because it stops after the last valid entry.
    always_comb begin
        addr = 8'h00;
        data = 8'h00;
        case (idx)
            3'd0: begin addr = A_SYS_CFG; data = 8'h60; end
            3'd1: begin addr = D_SYS_CFG; data = 8'h3C; end
            3'd2: begin addr = CLK1;      data = 8'h08; end
            3'd3: begin addr = CLK2;      data = 8'h86; end
            3'd4: begin addr = ADC_ENA;   data = 8'h0F; end
            default: begin addr = 8'h00; data = 8'h00; end
        endcase
    end

endmodule

// File: rtl/ads131_init_sequencer.sv
// ----------------------------------------------------------------------------
// ads131_init_sequencer
//   Brings an ADS131A0x from power-up to continuous conversion and then
//   requests a data-frame read on every DRDY falling edge.
//   Ports:
//     system_clock in   1  system clock
//     reset        in   1  synchronous active-high reset
//     start        in   1  pulse: (re)start init from IDLE, RUN or ERROR
//     drdy         in   1  ADC DRDY (active low, already synchronised)
//     adc_reset_n  out  1  ADC hardware reset pin
//     xfer_req     out  1  request to SPI engine, held until xfer_done
//     xfer_cmd     out 16  command word for the requested transaction
//     xfer_done    in   1  pulse: transaction finished, xfer_resp valid
//     xfer_resp    in  16  response word (answers the previous command)
//     frame_req    out  1  pulse: read one data frame (RUN only)
//     busy         out  1  sequence in progress
//     ready        out  1  converting (RUN)
//     error        out  1  sequence aborted (ERROR)
//     error_code   out  3  reason for the abort
// ----------------------------------------------------------------------------
module ads131_init_sequencer
    import ads131_pkg::*;
#(
    parameter int          RESET_LOW_CYCLES  = 50,
    parameter int          RESET_WAIT_CYCLES = 2500,
    parameter int          READY_POLLS       = 64,
    parameter logic [15:0] READY_WORD        = 16'hFF04,
    parameter int          CFG_COUNT         = 5
) (
    input  logic        system_clock,
    input  logic        reset,
    input  logic        start,
    input  logic        drdy,
    output logic        adc_reset_n,
    output logic        xfer_req,
    output logic [15:0] xfer_cmd,
    input  logic        xfer_done,
    input  logic [15:0] xfer_resp,
    output logic        frame_req,
    output logic        busy,
    output logic        ready,
    output logic        error,
    output logic [2:0]  error_code
);

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESET_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] POLL_MAX  = CNT_W'(READY_POLLS);
    localparam logic [2:0]       CFG_LAST  = 3'(CFG_COUNT - 1);

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] poll_q,       poll_d;
    logic [2:0]       idx_q,        idx_d;
    logic             null_phase_q, null_phase_d;
    logic             xfer_req_q,   xfer_req_d;
    logic [15:0]      xfer_cmd_q,   xfer_cmd_d;
    logic             frame_req_q,  frame_req_d;
    logic [2:0]       err_code_q,   err_code_d;
    logic             drdy_prev_q,  drdy_prev_d;

    logic [7:0]       rom_addr;
    logic [7:0]       rom_data;
    logic [15:0]      phase_cmd;
    logic [15:0]      phase_expect;
    logic [2:0]       phase_err;
    state_t           phase_next;
    logic [CNT_W-1:0] poll_inc;
    logic             drdy_fall;
    logic             restart;

    ads131_cfg_rom u_cfg_rom (
        .idx  (idx_q),
        .addr (rom_addr),
        .data (rom_data)
    );

    assign drdy_fall = drdy_prev_q & ~drdy;
    assign poll_inc  = sat_inc(poll_q);
    assign restart   = start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR);

    // Per-state command, the echo its following NULL must return, the error
    // raised on a bad echo and the state entered on a good one.
    always_comb begin
        phase_cmd    = CMD_NULL;
        phase_expect = CMD_NULL;
        phase_err    = ERR_NONE;
        phase_next   = state_q;
        case (state_q)
            S_UNLOCK: begin
                phase_cmd    = CMD_UNLOCK;
                phase_expect = CMD_UNLOCK;
                phase_err    = ERR_UNLOCK;
                phase_next   = S_CFG;
            end
            S_CFG: begin
                phase_cmd    = wreg_cmd(rom_addr, rom_data);
                phase_expect = wreg_echo(rom_addr, rom_data);
                phase_err    = ERR_WREG;
                phase_next   = (idx_q == CFG_LAST) ? S_WAKEUP : S_CFG;
            end
            S_WAKEUP: begin
                phase_cmd    = CMD_WAKEUP;
                phase_expect = CMD_WAKEUP;
                phase_err    = ERR_WAKE_LOCK;
                phase_next   = S_LOCK;
            end
            S_LOCK: begin
                phase_cmd    = CMD_LOCK;
                phase_expect = CMD_LOCK;
                phase_err    = ERR_WAKE_LOCK;
                phase_next   = S_RUN;
            end
            default: ;
        endcase
    end

    // Main next-state logic. A transaction is launched whenever xfer_req is
    // low in a command state, so the cycle right after xfer_done is always
    // the mandatory idle gap. null_phase marks that the command itself has
    // gone out and the checking NULL is the one in flight.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        poll_d       = poll_q;
        idx_d        = idx_q;
        null_phase_d = null_phase_q;
        xfer_req_d   = xfer_req_q;
        xfer_cmd_d   = xfer_cmd_q;
        frame_req_d  = 1'b0;
        err_code_d   = err_code_q;
        drdy_prev_d  = drdy;

        case (state_q)
            S_RST_LOW: begin
                if (cnt_q == LOW_LAST) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_POLL;
                    cnt_d   = '0;
                    poll_d  = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_POLL: begin
                if (!xfer_req_q) begin
                    xfer_req_d = 1'b1;
                    xfer_cmd_d = CMD_NULL;
                end else if (xfer_done) begin
                    xfer_req_d = 1'b0;
                    if (xfer_resp == READY_WORD) begin
                        state_d      = S_UNLOCK;
                        null_phase_d = 1'b0;
                    end else begin
                        poll_d = poll_inc;
                        if (poll_inc >= POLL_MAX) begin
                            state_d    = S_ERROR;
                            err_code_d = ERR_READY_TIMEOUT;
                        end
                    end
                end
            end
            S_UNLOCK, S_CFG, S_WAKEUP, S_LOCK: begin
                if (!xfer_req_q) begin
                    xfer_req_d = 1'b1;
                    xfer_cmd_d = null_phase_q ? CMD_NULL : phase_cmd;
                end else if (xfer_done) begin
                    xfer_req_d = 1'b0;
                    if (!null_phase_q) begin
                        null_phase_d = 1'b1;
                    end else begin
                        null_phase_d = 1'b0;
                        if (xfer_resp != phase_expect) begin
                            state_d    = S_ERROR;
                            err_code_d = phase_err;
                        end else begin
                            state_d = phase_next;
                            if (state_q == S_CFG) begin
                                idx_d = (idx_q == CFG_LAST) ? 3'd0 : idx_q + 3'd1;
                            end
                        end
                    end
                end
            end
            S_RUN: begin
                frame_req_d = drdy_fall;
            end
            default: ;
        endcase

        // start from a resting state wipes all progress and the error code
        if (restart) begin
            state_d      = S_RST_LOW;
            cnt_d        = '0;
            poll_d       = '0;
            idx_d        = 3'd0;
            null_phase_d = 1'b0;
            xfer_req_d   = 1'b0;
            err_code_d   = ERR_NONE;
        end
    end

    // State and output registers; the DRDY history resets high so a line
    // that is already low after reset is not seen as a falling edge.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            poll_q       <= '0;
            idx_q        <= 3'd0;
            null_phase_q <= 1'b0;
            xfer_req_q   <= 1'b0;
            xfer_cmd_q   <= 16'h0000;
            frame_req_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            drdy_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            poll_q       <= poll_d;
            idx_q        <= idx_d;
            null_phase_q <= null_phase_d;
            xfer_req_q   <= xfer_req_d;
            xfer_cmd_q   <= xfer_cmd_d;
            frame_req_q  <= frame_req_d;
            err_code_q   <= err_code_d;
            drdy_prev_q  <= drdy_prev_d;
        end
    end

    assign adc_reset_n = (state_q != S_RST_LOW);
    assign xfer_req    = xfer_req_q;
    assign xfer_cmd    = xfer_cmd_q;
    assign frame_req   = frame_req_q;
    assign busy        = !(state_q == S_IDLE || state_q == S_RUN || state_q == S_ERROR);
    assign ready       = (state_q == S_RUN);
    assign error       = (state_q == S_ERROR);
    assign error_code  = err_code_q;

endmodule

// File: tb/tb_ads131_init_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ads131_init_sequencer
//   Bench for the ADS131A0x init sequencer. An ADC/SPI-engine responder
//   answers each transaction with the reply to the previous command; the
//   expected command stream and final status are derived from the scenario
//   (when READY appears, which echo is corrupted) independently of the RTL.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ads131_init_sequencer;

    logic        system_clock = 1'b0;
    logic        reset;
    logic        start;
    logic        drdy;
    logic        adc_reset_n;
    logic        xfer_req;
    logic [15:0] xfer_cmd;
    logic        xfer_done;
    logic [15:0] xfer_resp;
    logic        frame_req;
    logic        busy;
    logic        ready;
    logic        error;
    logic [2:0]  error_code;

    ads131_init_sequencer dut (
        .system_clock (system_clock),
        .reset        (reset),
        .start        (start),
        .drdy         (drdy),
        .adc_reset_n  (adc_reset_n),
        .xfer_req     (xfer_req),
        .xfer_cmd     (xfer_cmd),
        .xfer_done    (xfer_done),
        .xfer_resp    (xfer_resp),
        .frame_req    (frame_req),
        .busy         (busy),
        .ready        (ready),
        .error        (error),
        .error_code   (error_code)
    );

    // 50 MHz system clock
    always #10 system_clock = ~system_clock;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Scenario description and reference-model state
    int          readyAt;
    int          faultKind;
    int          faultIdx;
    int          pollNum;
    logic [15:0] prevCmd;
    bit          stallResp = 1'b0;
    logic [15:0] obsCmds[$];
    logic [15:0] expCmds[$];
    int          expErrCode;
    int          lowCycles   = 0;
    int          framePulses = 0;
    logic [15:0] respCmd;
    int          respLat;

    logic [7:0] cfgAddr [5] = '{8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
    logic [7:0] cfgData [5] = '{8'h60, 8'h3C, 8'h08, 8'h86, 8'h0F};

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One-cycle start pulse driven between clock edges
    task automatic applyStimulus();
        @(negedge system_clock);
        start = 1'b1;
        @(negedge system_clock);
        start = 1'b0;
    endtask

    // Expected command stream and final error code for the current scenario
    task automatic buildExpected();
        expCmds.delete();
        expErrCode = 0;
        if (readyAt < 1 || readyAt > 64) begin
            repeat (64) expCmds.push_back(16'h0000);
            expErrCode = 1;
            return;
        end
        repeat (readyAt) expCmds.push_back(16'h0000);
        expCmds.push_back(16'h0655);
        expCmds.push_back(16'h0000);
        if (faultKind == 1) begin
            expErrCode = 2;
            return;
        end
        for (int i = 0; i < 5; i++) begin
            expCmds.push_back(16'h4000 + {cfgAddr[i], cfgData[i]});
            expCmds.push_back(16'h0000);
            if (faultKind == 2 && faultIdx == i) begin
                expErrCode = 3;
                return;
            end
        end
        expCmds.push_back(16'h0033);
        expCmds.push_back(16'h0000);
        if (faultKind == 3) begin
            expErrCode = 4;
            return;
        end
        expCmds.push_back(16'h0555);
        expCmds.push_back(16'h0000);
        if (faultKind == 4) expErrCode = 4;
    endtask

    // ADC behaviour: the word returned answers the previous command
    task automatic modelResponse(input logic [15:0] prev, output logic [15:0] r);
        if (prev == 16'h0655) begin
            r = (faultKind == 1) ? 16'h0656 : 16'h0655;
        end else if (prev == 16'h0033) begin
            r = (faultKind == 3) ? 16'h0032 : 16'h0033;
        end else if (prev == 16'h0555) begin
            r = (faultKind == 4) ? 16'h0554 : 16'h0555;
        end else if (prev[15:12] == 4'h4) begin
            r = {4'h2, prev[11:0]};
            if (faultKind == 2 && prev[11:8] == cfgAddr[faultIdx][3:0]) r = r ^ 16'h0001;
        end else begin
            pollNum++;
            r = (pollNum == readyAt) ? 16'hFF04 : (16'($urandom) & 16'h7FFF);
        end
    endtask

    // SPI engine responder with random latency; also checks the handshake
    initial begin
        xfer_done = 1'b0;
        xfer_resp = 16'h0000;
        forever begin
            @(posedge system_clock);
            #1;
            if (xfer_req === 1'b1) begin
                respCmd = xfer_cmd;
                respLat = $urandom_range(1, 4);
                repeat (respLat) begin
                    @(posedge system_clock);
                    #1;
                    if (xfer_req === 1'b1) checkOutput("cmd_stable", xfer_cmd, respCmd);
                end
                while (stallResp) begin
                    @(posedge system_clock);
                    #1;
                end
                modelResponse(prevCmd, xfer_resp);
                prevCmd = respCmd;
                obsCmds.push_back(respCmd);
                xfer_done = 1'b1;
                @(posedge system_clock);
                #1;
                xfer_done = 1'b0;
                checkOutput("req_drop", xfer_req, 0);
            end
        end
    end

    // Counts reset-pin low cycles and frame_req pulse cycles
    always @(negedge system_clock) begin
        if (adc_reset_n === 1'b0) lowCycles++;
        if (frame_req === 1'b1) framePulses++;
    end

    // Full init run for one scenario, then compare stream and final status
    task automatic runScenario(input string tag, input int rdy, input int fk, input int fidx);
        int waitCycles;
        readyAt   = rdy;
        faultKind = fk;
        faultIdx  = fidx;
        buildExpected();
        @(posedge system_clock);
        obsCmds.delete();
        prevCmd   = 16'h0000;
        pollNum   = 0;
        lowCycles = 0;
        applyStimulus();
        checkOutput({tag, "_busy_at_start"}, busy, 1);
        checkOutput({tag, "_rstn_at_start"}, adc_reset_n, 0);
        checkOutput({tag, "_err_cleared"}, error, 0);
        checkOutput({tag, "_code_cleared"}, error_code, 0);
        checkOutput({tag, "_ready_at_start"}, ready, 0);
        repeat (60) @(negedge system_clock);
        applyStimulus();
        waitCycles = 0;
        while (!(ready === 1'b1 || error === 1'b1) && waitCycles < 20000) begin
            @(negedge system_clock);
            waitCycles++;
        end
        checkOutput({tag, "_timeout"}, (waitCycles >= 20000), 0);
        repeat (20) @(negedge system_clock);
        checkOutput({tag, "_rst_low_cycles"}, lowCycles, 50);
        checkOutput({tag, "_cmd_count"}, obsCmds.size(), expCmds.size());
        for (int i = 0; i < expCmds.size() && i < obsCmds.size(); i++)
            checkOutput($sformatf("%s_cmd%0d", tag, i), obsCmds[i], expCmds[i]);
        checkOutput({tag, "_ready"}, ready, (expErrCode == 0));
        checkOutput({tag, "_error"}, error, (expErrCode != 0));
        checkOutput({tag, "_error_code"}, error_code, expErrCode);
        checkOutput({tag, "_busy_end"}, busy, 0);
        checkOutput({tag, "_req_idle"}, xfer_req, 0);
    endtask

    // Three DRDY falling edges in RUN, one held low for a long time
    task automatic runDrdy();
        int hold;
        @(posedge system_clock);
        framePulses = 0;
        for (int k = 0; k < 3; k++) begin
            hold = (k == 1) ? 12 : $urandom_range(2, 5);
            @(negedge system_clock);
            checkOutput($sformatf("frame_before%0d", k), frame_req, 0);
            drdy = 1'b0;
            @(negedge system_clock);
            checkOutput($sformatf("frame_pulse%0d", k), frame_req, 1);
            @(negedge system_clock);
            checkOutput($sformatf("frame_after%0d", k), frame_req, 0);
            repeat (hold) @(negedge system_clock);
            drdy = 1'b1;
            repeat (3) @(negedge system_clock);
        end
        @(posedge system_clock);
        checkOutput("frame_count", framePulses, 3);
    endtask

    // Reset while a WREG request is outstanding, then a late xfer_done
    task automatic runResetInCfg();
        int n;
        readyAt   = 2;
        faultKind = 0;
        faultIdx  = 0;
        @(posedge system_clock);
        obsCmds.delete();
        prevCmd = 16'h0000;
        pollNum = 0;
        applyStimulus();
        n = 0;
        while (!(xfer_req === 1'b1 && xfer_cmd[15:12] === 4'h4) && n < 10000) begin
            @(negedge system_clock);
            n++;
        end
        checkOutput("cfgrst_reach_cfg", (n >= 10000), 0);
        stallResp = 1'b1;
        reset     = 1'b1;
        @(posedge system_clock);
        #1;
        checkOutput("cfgrst_rstn", adc_reset_n, 1);
        checkOutput("cfgrst_req", xfer_req, 0);
        checkOutput("cfgrst_cmd", xfer_cmd, 0);
        checkOutput("cfgrst_frame", frame_req, 0);
        checkOutput("cfgrst_busy", busy, 0);
        checkOutput("cfgrst_ready", ready, 0);
        checkOutput("cfgrst_error", error, 0);
        checkOutput("cfgrst_code", error_code, 0);
        @(negedge system_clock);
        reset     = 1'b0;
        stallResp = 1'b0;
        repeat (8) @(negedge system_clock);
        checkOutput("late_done_busy", busy, 0);
        checkOutput("late_done_req", xfer_req, 0);
        checkOutput("late_done_rstn", adc_reset_n, 1);
        checkOutput("late_done_error", error, 0);
        checkOutput("late_done_ready", ready, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        drdy  = 1'b1;
        repeat (3) @(negedge system_clock);
        checkOutput("rst_rstn", adc_reset_n, 1);
        checkOutput("rst_req", xfer_req, 0);
        checkOutput("rst_cmd", xfer_cmd, 0);
        checkOutput("rst_frame", frame_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_code", error_code, 0);
        reset = 1'b0;

        // DRDY activity in IDLE must not request frames
        @(posedge system_clock);
        framePulses = 0;
        @(negedge system_clock);
        drdy = 1'b0;
        repeat (4) @(negedge system_clock);
        drdy = 1'b1;
        repeat (3) @(negedge system_clock);
        checkOutput("idle_no_frame", framePulses, 0);

        runScenario("ready3", 3, 0, 0);
        runDrdy();
        runScenario("never_ready", 0, 0, 0);
        runScenario("restart", $urandom_range(1, 8), 0, 0);
        runScenario("wreg_dsys", 2, 2, 1);
        runResetInCfg();
        for (int r = 0; r < 4; r++)
            runScenario($sformatf("rand%0d", r), $urandom_range(1, 10),
                        $urandom_range(0, 4), $urandom_range(0, 4));
        runScenario("ready64", 64, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
